regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// Write-back arbiter in front of the 32x32 register file's two write ports (W1=a, W2=b).
// Accepts write requests from NREQ producers (e.g. ALU, MULT, LSU) over valid/ready.
// Grants up to two requests per cycle, round-robin, and drives each granted write on a port through a registered stage.
// Also exports a pending-write mask that hazard/forwarding logic uses.
// PARAMETERS
// NREQ    3   number of write requesters (2..8)
// ADDR_W  5   register address width
// DATA_W  32  register data width
// PORTS
// clk          in   1              clock, all state on rising edge
// rst          in   1              synchronous reset, active-high
// hold_i       in   1              stall: no grants this cycle
// req_valid_i  in   NREQ           request valid per producer
// req_addr_i   in   NREQ*ADDR_W    destination register, producer i at [i*ADDR_W +: ADDR_W]
// req_data_i   in   NREQ*DATA_W    write data, producer i at [i*DATA_W +: DATA_W]
// req_ready_o  out  NREQ           request accepted this cycle (combinational)
// waddr_a_o    out  ADDR_W         to regfile waddr_a_i
// wdata_a_o    out  DATA_W         to regfile wdata_a_i
// we_a_o       out  1              to regfile we_a_i
// waddr_b_o    out  ADDR_W         to regfile waddr_b_i
// wdata_b_o    out  DATA_W         to regfile wdata_b_i
// we_b_o       out  1              to regfile we_b_i
// pending_o    out  2**ADDR_W      bit r=1: a write to r is requested or in the output stage
// BEHAVIOUR
// - Clock is clk; reset is synchronous and active-high (rst), one clock domain.
// - Reset: rr_ptr=0; we_a_o=we_b_o=0; waddr_*_o=0; wdata_*_o=0. req_ready_o=0 while rst=1.
// - Handshake: transfer when valid&ready in the same cycle. Producer holds valid, addr and data
//   stable until ready. Ready never depends on ready.
// - x0: a valid request with addr==0 is always ready (unless hold_i/rst), takes no port, and is dropped.
// - Scan order: start at rr_ptr, ascending index, wrap mod NREQ. First eligible nonzero request -> port a.
//   Second -> port b. Remaining requests wait.
// - Same-address rule: a request whose addr equals the port-a grant is not granted to b this cycle.
//   Scan continues past it, so write order per register is preserved.
// - Latency: a grant in cycle N drives we_*_o/waddr_*_o/wdata_*_o in cycle N+1, for exactly one cycle.
//   A port that is not granted drives we=0 in N+1; its addr/data hold their previous value.
// - rr_ptr update: on any nonzero grant, rr_ptr <= (highest-scan-order granted index + 1) mod NREQ.
//   rr_ptr is unchanged when there are no grants or only x0 grants.
// - hold_i=1: all req_ready_o=0, rr_ptr holds, next-cycle we_a_o=we_b_o=0. A write already in the
//   output stage still completes this cycle.
// - pending_o = decode(valid nonzero req addrs) | decode(waddr_a_o if we_a_o) | decode(waddr_b_o if we_b_o).
//   Bit 0 is always 0. Combinational.
// - Reset mid-operation: output stage is cleared at the edge and in-flight writes are lost.
//   Producers must re-issue.
// - Starvation bound: with hold_i=0, a valid request is granted within ceil(NREQ/2) cycles,
//   not counting same-address deferrals.
// STRUCTURE
// - regfile_pkg: ADDR_W, DATA_W, NREG=32 constants; typedef struct packed {logic [ADDR_W-1:0] addr;
//   logic [DATA_W-1:0] data;} wb_req_t; typedef wb_req_t wb_port_t (output stage).
// - Sub-module rr_pick2: combinational round-robin pick-two.
//   Inputs are eligibility vector, addresses and rr_ptr; outputs are gnt_a/gnt_b one-hot and valid flags.
//   The top level owns rr_ptr, the output registers, x0 handling and pending_o.
// TESTING
// - Reset: assert rst 2 cycles with all valid=1 -> ready=0, we_a_o=we_b_o=0, waddr/wdata=0, pending_o
//   shows only request addrs.
// - Single: req0 valid addr=5 data=0xDEADBEEF -> ready0=1 in cycle N; cycle N+1 we_a_o=1 waddr_a_o=5
//   wdata_a_o=0xDEADBEEF, we_b_o=0.
// - Three-way contention, addrs 1/2/3, rr_ptr=0 -> cycle N grants 0->a, 1->b; cycle N+1 grants 2->a,
//   rr_ptr=0; all three writes seen over 2 cycles.
// - Same address: req0 and req1 both addr=7 (data 0x11, 0x22) -> cycle N only req0 writes 7=0x11;
//   next cycle req1 writes 7=0x22; pending_o[7]=1 throughout.
// - x0 and hold: req2 addr=0 -> ready2=1, no we. Assert hold_i with req0 valid -> ready0=0, we=0 next
//   cycle, rr_ptr unchanged.
// - Reset mid-stream: rst asserted the cycle after a grant -> we_a_o=0 at next edge; random 10k-cycle run
//   vs. a register-file model checks every register's final value and write order.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and write-back request types for the register file
// write path.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef wb_req_t wb_port_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational round-robin pick-two. The scan starts at rr_ptr and wraps.
// Port b skips any request that targets the same register as port a.
module rr_pick2 #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 5,
  parameter int PTR_W  = 2
) (
  input  logic [NREQ-1:0]        elig,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [PTR_W-1:0]       rr_ptr,
  output logic [NREQ-1:0]        gnt_a,
  output logic [NREQ-1:0]        gnt_b,
  output logic                   vld_a,
  output logic                   vld_b
);
  localparam logic [PTR_W:0] NREQ_L = (PTR_W+1)'(NREQ);

  logic [PTR_W:0]    pos;
  logic [PTR_W-1:0]  idx;
  logic [ADDR_W-1:0] addr_a;

  always_comb begin
    gnt_a  = '0;
    gnt_b  = '0;
    vld_a  = 1'b0;
    vld_b  = 1'b0;
    addr_a = '0;
    pos    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= NREQ_L) pos = pos - NREQ_L;
      idx = pos[PTR_W-1:0];
      if (elig[idx]) begin
        if (!vld_a) begin
          vld_a      = 1'b1;
          gnt_a[idx] = 1'b1;
          addr_a     = addr[idx*ADDR_W +: ADDR_W];
        end else if (!vld_b && (addr[idx*ADDR_W +: ADDR_W] != addr_a)) begin
          vld_b      = 1'b1;
          gnt_b[idx] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the two register-file write ports. It grants up to
// two producers per cycle and exports a pending-write mask for hazard logic.
module regfile_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*DATA_W-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [ADDR_W-1:0]      waddr_a_o,
  output logic [DATA_W-1:0]      wdata_a_o,
  output logic                   we_a_o,
  output logic [ADDR_W-1:0]      waddr_b_o,
  output logic [DATA_W-1:0]      wdata_b_o,
  output logic                   we_b_o,
  output logic [2**ADDR_W-1:0]   pending_o
);
  import regfile_pkg::*;

  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [NREQ-1:0]   nz, zero_req, elig, gnt_a, gnt_b;
  logic              vld_a, vld_b, go;
  logic [ADDR_W-1:0] sel_addr_a, sel_addr_b;
  logic [DATA_W-1:0] sel_data_a, sel_data_b;
  logic [PTR_W-1:0]  idx_a, idx_b;

  logic              vld_a_p1, vld_b_p1;
  logic [ADDR_W-1:0] waddr_a_p1, waddr_b_p1;
  logic [DATA_W-1:0] wdata_a_p1, wdata_b_p1;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == LAST) ? '0 : idx + PTR_W'(1);
  endfunction

  always_comb begin
    nz = '0;
    for (int i = 0; i < NREQ; i++) nz[i] = |req_addr_i[i*ADDR_W +: ADDR_W];
  end

  // x0 writes are acknowledged and discarded without taking a port.
  assign go          = ~hold_i & ~rst;
  assign zero_req    = req_valid_i & ~nz;
  assign elig        = go ? (req_valid_i & nz) : '0;
  assign req_ready_o = go ? (gnt_a | gnt_b | zero_req) : '0;

  rr_pick2 #(.NREQ(NREQ), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_pick (
    .elig   (elig),
    .addr   (req_addr_i),
    .rr_ptr (rr_ptr),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .vld_a  (vld_a),
    .vld_b  (vld_b)
  );

  always_comb begin
    sel_addr_a = '0;
    sel_data_a = '0;
    sel_addr_b = '0;
    sel_data_b = '0;
    idx_a      = '0;
    idx_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_a[i]) begin
        sel_addr_a = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_data_a = req_data_i[i*DATA_W +: DATA_W];
        idx_a      = PTR_W'(i);
      end
      if (gnt_b[i]) begin
        sel_addr_b = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_data_b = req_data_i[i*DATA_W +: DATA_W];
        idx_b      = PTR_W'(i);
      end
    end
  end

  // Output stage: grants become one-cycle write strobes; idle ports keep addr/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      vld_a_p1   <= 1'b0;
      vld_b_p1   <= 1'b0;
      waddr_a_p1 <= '0;
      wdata_a_p1 <= '0;
      waddr_b_p1 <= '0;
      wdata_b_p1 <= '0;
    end else begin
      vld_a_p1 <= vld_a;
      vld_b_p1 <= vld_b;
      if (vld_a) begin
        waddr_a_p1 <= sel_addr_a;
        wdata_a_p1 <= sel_data_a;
      end
      if (vld_b) begin
        waddr_b_p1 <= sel_addr_b;
        wdata_b_p1 <= sel_data_b;
      end
      if (vld_b)      rr_ptr <= next_ptr(idx_b);
      else if (vld_a) rr_ptr <= next_ptr(idx_a);
    end
  end

  assign we_a_o    = vld_a_p1;
  assign waddr_a_o = waddr_a_p1;
  assign wdata_a_o = wdata_a_p1;
  assign we_b_o    = vld_b_p1;
  assign waddr_b_o = waddr_b_p1;
  assign wdata_b_o = wdata_b_p1;

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_valid_i[i]) pending_o[req_addr_i[i*ADDR_W +: ADDR_W]] = 1'b1;
    if (vld_a_p1) pending_o[waddr_a_p1] = 1'b1;
    if (vld_b_p1) pending_o[waddr_b_p1] = 1'b1;
    pending_o[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a rule-level model predicts
// handshakes and port writes, and a monitor checks the DUT outputs.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = ADDR_W;
  localparam int DW   = DATA_W;
  localparam int QD   = 64;

  logic            clk = 1'b0;
  logic            rst, hold;
  logic [NREQ-1:0] valid;
  logic [NREQ*AW-1:0] addr_f;
  logic [NREQ*DW-1:0] data_f;
  logic [NREQ-1:0] req_ready_o;
  logic [AW-1:0]   waddr_a_o, waddr_b_o;
  logic [DW-1:0]   wdata_a_o, wdata_b_o;
  logic            we_a_o, we_b_o;
  logic [2**AW-1:0] pending_o;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .hold_i(hold),
    .req_valid_i(valid), .req_addr_i(addr_f), .req_data_i(data_f),
    .req_ready_o(req_ready_o),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
    .pending_o(pending_o)
  );

  typedef struct packed {
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_a;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;
  } exp_t;

  wb_req_t pbuf [NREQ][QD];
  int      head [NREQ];
  int      cnt  [NREQ];
  logic [NREQ-1:0] acc = '0;
  exp_t    exp_q[$];
  int      compared = 0, mismatched = 0;
  int      rr_m = 0;
  bit      gen_en = 0;
  logic [AW-1:0] last_addr_a = '0, last_addr_b = '0;
  logic [DW-1:0] last_data_a = '0, last_data_b = '0;
  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] dut_rf   [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      if (mismatched <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic push(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (cnt[p] < QD) begin
      pbuf[p][(head[p] + cnt[p]) % QD] = '{addr: a, data: d};
      cnt[p]++;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      valid[i] = (cnt[i] > 0);
      if (cnt[i] > 0) begin
        addr_f[i*AW +: AW] = pbuf[i][head[i]].addr;
        data_f[i*DW +: DW] = pbuf[i][head[i]].data;
      end else begin
        addr_f[i*AW +: AW] = AW'($urandom);
        data_f[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic hold_v);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) begin
        head[i] = (head[i] + 1) % QD;
        cnt[i]--;
      end
    if (gen_en)
      for (int i = 0; i < NREQ; i++)
        if (cnt[i] < QD - 2 && $urandom_range(0, 2) == 0)
          push(i, ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31)),
               $urandom);
    rst  = rst_v;
    hold = hold_v;
    drive_reqs();
  endtask

  task automatic wait_drain(input string name, input int budget, output int n);
    n = 0;
    while ((cnt[0] + cnt[1] + cnt[2]) > 0 && n <= budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (n > budget) check({name, "_timeout"}, 64'(n), 64'(budget));
  endtask

  // Reference: scan producers in round-robin order from the rules, predict
  // this cycle's handshakes and next cycle's port contents.
  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] rdy;
    logic [AW-1:0] a, ga_addr;
    int ga, gb, i;
    #1;
    rdy = '0;
    ga = -1;
    gb = -1;
    ga_addr = '0;
    e = '0;
    if (rst) begin
      last_addr_a = '0; last_data_a = '0;
      last_addr_b = '0; last_data_b = '0;
      rr_m = 0;
    end else begin
      if (!hold)
        for (int k = 0; k < NREQ; k++) begin
          i = (rr_m + k) % NREQ;
          a = addr_f[i*AW +: AW];
          if (valid[i]) begin
            if (a == 0) rdy[i] = 1'b1;
            else if (ga < 0) begin
              ga = i; ga_addr = a; rdy[i] = 1'b1;
              last_addr_a = a; last_data_a = data_f[i*DW +: DW];
            end else if (gb < 0 && a != ga_addr) begin
              gb = i; rdy[i] = 1'b1;
              last_addr_b = a; last_data_b = data_f[i*DW +: DW];
            end
          end
        end
      e.we_a = (ga >= 0);
      e.we_b = (gb >= 0);
      if (gb >= 0) rr_m = (gb + 1) % NREQ;
      else if (ga >= 0) rr_m = (ga + 1) % NREQ;
    end
    e.addr_a = last_addr_a; e.data_a = last_data_a;
    e.addr_b = last_addr_b; e.data_b = last_data_b;
    check("req_ready", 64'(req_ready_o), 64'(rdy));
    acc = rdy;
    if (e.we_a) model_rf[e.addr_a] = e.data_a;
    if (e.we_b) model_rf[e.addr_b] = e.data_b;
    exp_q.push_back(e);
  end

  // Monitor: the entry queued last cycle is what the output stage shows now.
  always @(negedge clk) begin
    exp_t e;
    logic [2**AW-1:0] pexp;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("we_a", 64'(we_a_o), 64'(e.we_a));
      check("waddr_a", 64'(waddr_a_o), 64'(e.addr_a));
      check("wdata_a", 64'(wdata_a_o), 64'(e.data_a));
      check("we_b", 64'(we_b_o), 64'(e.we_b));
      check("waddr_b", 64'(waddr_b_o), 64'(e.addr_b));
      check("wdata_b", 64'(wdata_b_o), 64'(e.data_b));
      pexp = '0;
      for (int i = 0; i < NREQ; i++)
        if (valid[i] && addr_f[i*AW +: AW] != 0) pexp[addr_f[i*AW +: AW]] = 1'b1;
      if (e.we_a) pexp[e.addr_a] = 1'b1;
      if (e.we_b) pexp[e.addr_b] = 1'b1;
      check("pending", 64'(pending_o), 64'(pexp));
      if (we_a_o === 1'b1) dut_rf[waddr_a_o] = wdata_a_o;
      if (we_b_o === 1'b1) dut_rf[waddr_b_o] = wdata_b_o;
    end
  end

  initial begin
    int n;
    for (int r = 0; r < 32; r++) begin
      model_rf[r] = '0;
      dut_rf[r]   = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
    rst  = 1'b1;
    hold = 1'b0;
    push(0, AW'(10), 32'hA0A0_0010);
    push(1, AW'(11), 32'hA0A0_0011);
    push(2, AW'(0),  32'hA0A0_0000);
    drive_reqs();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    wait_drain("reset_reqs", 10, n);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Single write on port a.
    push(0, AW'(5), 32'hDEAD_BEEF);
    drive_reqs();
    wait_drain("single", 10, n);
    check("single_cycles", 64'(n), 64'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("single_rf5", 64'(dut_rf[5]), 64'h0000_0000_DEAD_BEEF);

    // Three-way contention from a fresh pointer.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    push(0, AW'(1), 32'h0000_0101);
    push(1, AW'(2), 32'h0000_0202);
    push(2, AW'(3), 32'h0000_0303);
    drive_reqs();
    wait_drain("contention", 10, n);
    check("contention_cycles", 64'(n), 64'd2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("contention_rf1", 64'(dut_rf[1]), 64'h101);
    check("contention_rf2", 64'(dut_rf[2]), 64'h202);
    check("contention_rf3", 64'(dut_rf[3]), 64'h303);

    // Same destination register from two producers.
    push(0, AW'(7), 32'h11);
    push(1, AW'(7), 32'h22);
    drive_reqs();
    wait_drain("same_addr", 10, n);
    check("same_addr_cycles", 64'(n), 64'd2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("same_addr_rf7", 64'(dut_rf[7]), 64'h22);

    // x0 drop, then hold stalls a pending request.
    push(2, AW'(0), 32'h5555_5555);
    drive_reqs();
    wait_drain("x0", 10, n);
    push(0, AW'(4), 32'h4444_4444);
    hold = 1'b1;
    drive_reqs();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    wait_drain("after_hold", 10, n);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("hold_rf4", 64'(dut_rf[4]), 64'h4444_4444);

    // Reset the cycle after a grant.
    push(0, AW'(9), 32'h0000_00AA);
    drive_reqs();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Randomised traffic with occasional hold and reset.
    gen_en = 1;
    for (int c = 0; c < 10000; c++)
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0));
    gen_en = 0;
    wait_drain("final_drain", 400, n);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int r = 0; r < 32; r++)
      check($sformatf("rf_final_%0d", r), 64'(dut_rf[r]), 64'(model_rf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
